// File: rtl/bp_common_pkg.sv
// Shared types for the core request arbiter: processor configurations, slot
// states, request-source encoding and per-configuration width helpers.
package bp_common_pkg;

  typedef enum logic [1:0] {
    e_bp_single_core_cfg = 2'd0,
    e_bp_dual_core_cfg   = 2'd1
  } bp_params_e;

  typedef enum logic [1:0] {
    e_slot_empty     = 2'd0,
    e_slot_wait_meta = 2'd1,
    e_slot_ready     = 2'd2,
    e_slot_issued    = 2'd3
  } bp_slot_state_e;

  typedef enum logic {
    e_src_icache = 1'b0,
    e_src_dcache = 1'b1
  } bp_req_src_e;

  function automatic int unsigned bp_icache_req_width(bp_params_e cfg);
    case (cfg)
      e_bp_dual_core_cfg: return 48;
      default:            return 40;
    endcase
  endfunction

  function automatic int unsigned bp_dcache_req_width(bp_params_e cfg);
    case (cfg)
      e_bp_dual_core_cfg: return 56;
      default:            return 48;
    endcase
  endfunction

  function automatic int unsigned bp_icache_req_metadata_width(bp_params_e cfg);
    case (cfg)
      e_bp_dual_core_cfg: return 5;
      default:            return 4;
    endcase
  endfunction

  function automatic int unsigned bp_dcache_req_metadata_width(bp_params_e cfg);
    case (cfg)
      e_bp_dual_core_cfg: return 6;
      default:            return 6;
    endcase
  endfunction

  function automatic int unsigned bp_max(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bp_core_req_slot.sv
// One request slot per cache: captures a miss request and its metadata, holds
// it until issued, and retires it on the matching done.
module bp_core_req_slot
  import bp_common_pkg::*;
#(
  parameter int unsigned req_width_p  = 1,
  parameter int unsigned meta_width_p = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [req_width_p-1:0]  req_i,
  input  logic                    req_v_i,
  output logic                    ready_o,
  input  logic [meta_width_p-1:0] meta_i,
  input  logic                    meta_v_i,
  input  logic                    issue_i,
  input  logic                    done_i,
  output logic                    complete_o,
  output bp_slot_state_e          state_o,
  output logic [req_width_p-1:0]  req_o,
  output logic [meta_width_p-1:0] meta_o
);

  bp_slot_state_e          state_q, state_d;
  logic [req_width_p-1:0]  req_q;
  logic [meta_width_p-1:0] meta_q;
  logic                    req_capture, meta_capture;

  always_comb begin
    state_d      = state_q;
    req_capture  = 1'b0;
    meta_capture = 1'b0;
    case (state_q)
      e_slot_empty: if (req_v_i) begin
        req_capture  = 1'b1;
        meta_capture = meta_v_i;
        state_d      = meta_v_i ? e_slot_ready : e_slot_wait_meta;
      end
      e_slot_wait_meta: if (meta_v_i) begin
        meta_capture = 1'b1;
        state_d      = e_slot_ready;
      end
      e_slot_ready:  if (issue_i) state_d = e_slot_issued;
      e_slot_issued: if (done_i)  state_d = e_slot_empty;
      default:       state_d = e_slot_empty;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= e_slot_empty;
    else         state_q <= state_d;
  end

  // Payload is only written while the slot is filling, so it is stable once READY.
  always_ff @(posedge clk_i) begin
    if (req_capture)  req_q  <= req_i;
    if (meta_capture) meta_q <= meta_i;
  end

  assign ready_o    = ~reset_i & (state_q == e_slot_empty);
  assign complete_o = ~reset_i & done_i & (state_q == e_slot_issued);
  assign state_o    = state_q;
  assign req_o      = req_q;
  assign meta_o     = meta_q;

endmodule

// File: rtl/bp_core_req_arbiter.sv
// Merges I$ and D$ miss requests into one memory request stream and tracks
// outstanding requests. Define BP_REQ_ARB_DCACHE_PRIORITY_EN for fixed D$ priority.
module bp_core_req_arbiter
  import bp_common_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_single_core_cfg,
  localparam int unsigned icache_req_width_lp          = bp_icache_req_width(bp_params_p),
  localparam int unsigned dcache_req_width_lp          = bp_dcache_req_width(bp_params_p),
  localparam int unsigned icache_req_metadata_width_lp = bp_icache_req_metadata_width(bp_params_p),
  localparam int unsigned dcache_req_metadata_width_lp = bp_dcache_req_metadata_width(bp_params_p),
  localparam int unsigned req_field_width_lp  = bp_max(icache_req_width_lp, dcache_req_width_lp),
  localparam int unsigned meta_field_width_lp = bp_max(icache_req_metadata_width_lp,
                                                       dcache_req_metadata_width_lp),
  localparam int unsigned mem_req_width_lp    = req_field_width_lp + meta_field_width_lp + 1
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic [icache_req_width_lp-1:0]          icache_req_i,
  input  logic                                    icache_req_v_i,
  output logic                                    icache_req_ready_o,
  input  logic [icache_req_metadata_width_lp-1:0] icache_req_metadata_i,
  input  logic                                    icache_req_metadata_v_i,
  input  logic [dcache_req_width_lp-1:0]          dcache_req_i,
  input  logic                                    dcache_req_v_i,
  output logic                                    dcache_req_ready_o,
  input  logic [dcache_req_metadata_width_lp-1:0] dcache_req_metadata_i,
  input  logic                                    dcache_req_metadata_v_i,
  output logic                                    icache_req_complete_o,
  output logic                                    dcache_req_complete_o,
  output logic                                    credits_full_o,
  output logic                                    credits_empty_o,
  output logic [mem_req_width_lp-1:0]             mem_req_o,
  output logic                                    mem_req_v_o,
  input  logic                                    mem_req_ready_i,
  input  logic                                    mem_done_i,
  input  logic                                    mem_done_src_i
);

  bp_slot_state_e                          icache_state, dcache_state;
  logic [icache_req_width_lp-1:0]          icache_req_q;
  logic [dcache_req_width_lp-1:0]          dcache_req_q;
  logic [icache_req_metadata_width_lp-1:0] icache_meta_q;
  logic [dcache_req_metadata_width_lp-1:0] dcache_meta_q;
  logic icache_issue, dcache_issue, icache_done, dcache_done;
  logic icache_rdy, dcache_rdy, handshake;
  logic lock_q, lock_d;
  bp_req_src_e lock_src_q, lock_src_d, arb_src, grant_src;
  logic [1:0] count_q, count_d;

  assign icache_done  = mem_done_i & (mem_done_src_i == e_src_icache);
  assign dcache_done  = mem_done_i & (mem_done_src_i == e_src_dcache);
  assign icache_issue = handshake & (grant_src == e_src_icache);
  assign dcache_issue = handshake & (grant_src == e_src_dcache);

  bp_core_req_slot #(
    .req_width_p (icache_req_width_lp),
    .meta_width_p(icache_req_metadata_width_lp)
  ) icache_slot (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (icache_req_i),
    .req_v_i   (icache_req_v_i),
    .ready_o   (icache_req_ready_o),
    .meta_i    (icache_req_metadata_i),
    .meta_v_i  (icache_req_metadata_v_i),
    .issue_i   (icache_issue),
    .done_i    (icache_done),
    .complete_o(icache_req_complete_o),
    .state_o   (icache_state),
    .req_o     (icache_req_q),
    .meta_o    (icache_meta_q)
  );

  bp_core_req_slot #(
    .req_width_p (dcache_req_width_lp),
    .meta_width_p(dcache_req_metadata_width_lp)
  ) dcache_slot (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (dcache_req_i),
    .req_v_i   (dcache_req_v_i),
    .ready_o   (dcache_req_ready_o),
    .meta_i    (dcache_req_metadata_i),
    .meta_v_i  (dcache_req_metadata_v_i),
    .issue_i   (dcache_issue),
    .done_i    (dcache_done),
    .complete_o(dcache_req_complete_o),
    .state_o   (dcache_state),
    .req_o     (dcache_req_q),
    .meta_o    (dcache_meta_q)
  );

  assign icache_rdy = (icache_state == e_slot_ready);
  assign dcache_rdy = (dcache_state == e_slot_ready);

`ifdef BP_REQ_ARB_DCACHE_PRIORITY_EN
  assign arb_src = dcache_rdy ? e_src_dcache : e_src_icache;
`else
  bp_req_src_e prio_q, prio_d;

  always_comb begin
    if (icache_rdy & dcache_rdy) arb_src = prio_q;
    else if (dcache_rdy)         arb_src = e_src_dcache;
    else                         arb_src = e_src_icache;
  end

  assign prio_d = handshake
                ? ((grant_src == e_src_icache) ? e_src_dcache : e_src_icache)
                : prio_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) prio_q <= e_src_icache;
    else         prio_q <= prio_d;
  end
`endif

  // An offered request keeps its source until accepted, even if the other slot becomes READY.
  assign grant_src   = lock_q ? lock_src_q : arb_src;
  assign mem_req_v_o = ~reset_i & (lock_q | icache_rdy | dcache_rdy);
  assign handshake   = mem_req_v_o & mem_req_ready_i;

  always_comb begin
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    if (handshake) begin
      lock_d = 1'b0;
    end else if (mem_req_v_o) begin
      lock_d     = 1'b1;
      lock_src_d = grant_src;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_q     <= 1'b0;
      lock_src_q <= e_src_icache;
    end else begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
    end
  end

  logic [req_field_width_lp-1:0]  icache_req_ext, dcache_req_ext;
  logic [meta_field_width_lp-1:0] icache_meta_ext, dcache_meta_ext;

  always_comb begin
    icache_req_ext  = '0;
    dcache_req_ext  = '0;
    icache_meta_ext = '0;
    dcache_meta_ext = '0;
    icache_req_ext[icache_req_width_lp-1:0]           = icache_req_q;
    dcache_req_ext[dcache_req_width_lp-1:0]           = dcache_req_q;
    icache_meta_ext[icache_req_metadata_width_lp-1:0] = icache_meta_q;
    dcache_meta_ext[dcache_req_metadata_width_lp-1:0] = dcache_meta_q;
  end

  assign mem_req_o = (grant_src == e_src_dcache)
                   ? {1'b1, dcache_meta_ext, dcache_req_ext}
                   : {1'b0, icache_meta_ext, icache_req_ext};

  // A single done can only retire one slot, so at most one decrement per cycle.
  assign count_d = count_q + {1'b0, handshake}
                 - {1'b0, icache_req_complete_o | dcache_req_complete_o};

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= 2'd0;
    else         count_q <= count_d;
  end

  assign credits_full_o  = ~reset_i & (count_q == 2'd2);
  assign credits_empty_o = reset_i | (count_q == 2'd0);

endmodule

// File: tb/tb_bp_core_req_arbiter.sv
// Directed bench for bp_core_req_arbiter with a transaction-level reference model.
module tb_bp_core_req_arbiter;

  localparam int IW = 40, DW = 48, IMW = 4, DMW = 6, MW = 55;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_i = 1'b1;
  logic [IW-1:0]  icache_req = '0;
  logic           icache_req_v = 1'b0;
  logic           icache_req_ready;
  logic [IMW-1:0] icache_meta = '0;
  logic           icache_meta_v = 1'b0;
  logic [DW-1:0]  dcache_req = '0;
  logic           dcache_req_v = 1'b0;
  logic           dcache_req_ready;
  logic [DMW-1:0] dcache_meta = '0;
  logic           dcache_meta_v = 1'b0;
  logic           icache_complete, dcache_complete;
  logic           credits_full, credits_empty;
  logic [MW-1:0]  mem_req;
  logic           mem_req_v;
  logic           mem_req_ready = 1'b0;
  logic           mem_done = 1'b0;
  logic           mem_done_src = 1'b0;

  bp_core_req_arbiter dut (
    .clk_i                  (clk),
    .reset_i                (reset_i),
    .icache_req_i           (icache_req),
    .icache_req_v_i         (icache_req_v),
    .icache_req_ready_o     (icache_req_ready),
    .icache_req_metadata_i  (icache_meta),
    .icache_req_metadata_v_i(icache_meta_v),
    .dcache_req_i           (dcache_req),
    .dcache_req_v_i         (dcache_req_v),
    .dcache_req_ready_o     (dcache_req_ready),
    .dcache_req_metadata_i  (dcache_meta),
    .dcache_req_metadata_v_i(dcache_meta_v),
    .icache_req_complete_o  (icache_complete),
    .dcache_req_complete_o  (dcache_complete),
    .credits_full_o         (credits_full),
    .credits_empty_o        (credits_empty),
    .mem_req_o              (mem_req),
    .mem_req_v_o            (mem_req_v),
    .mem_req_ready_i        (mem_req_ready),
    .mem_done_i             (mem_done),
    .mem_done_src_i         (mem_done_src)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each cache holds at most one request that is either
  // filling, waiting to be sent, or out at memory.
  bit        m_have_req[2];
  bit        m_have_meta[2];
  bit        m_issued[2];
  logic [47:0] m_req[2];
  logic [5:0]  m_meta[2];
  int        m_hold  = -1;
  int        m_favor = 0;

  bit rdy0, rdy1, e_v, hs, dn0, dn1, cap_r0, cap_r1, cap_m0, cap_m1;
  int e_src, outstanding;
  logic [MW-1:0] e_req;

  always @(negedge clk) begin
    if (reset_i) begin
      check_bit("rst_icache_ready", icache_req_ready, 1'b0);
      check_bit("rst_dcache_ready", dcache_req_ready, 1'b0);
      check_bit("rst_mem_v", mem_req_v, 1'b0);
      check_bit("rst_icache_complete", icache_complete, 1'b0);
      check_bit("rst_dcache_complete", dcache_complete, 1'b0);
      check_bit("rst_credits_empty", credits_empty, 1'b1);
      check_bit("rst_credits_full", credits_full, 1'b0);
      for (int s = 0; s < 2; s++) begin
        m_have_req[s] = 0; m_have_meta[s] = 0; m_issued[s] = 0;
      end
      m_hold = -1;
      m_favor = 0;
    end else begin
      rdy0 = m_have_req[0] && m_have_meta[0] && !m_issued[0];
      rdy1 = m_have_req[1] && m_have_meta[1] && !m_issued[1];
      e_v  = (m_hold >= 0) || rdy0 || rdy1;
      if (m_hold >= 0)       e_src = m_hold;
`ifdef BP_REQ_ARB_DCACHE_PRIORITY_EN
      else if (rdy0 && rdy1) e_src = 1;
`else
      else if (rdy0 && rdy1) e_src = m_favor;
`endif
      else                   e_src = rdy1 ? 1 : 0;
      outstanding = int'(m_issued[0]) + int'(m_issued[1]);
      dn0 = mem_done && !mem_done_src && m_issued[0];
      dn1 = mem_done &&  mem_done_src && m_issued[1];

      check_bit("model_icache_ready", icache_req_ready, !m_have_req[0]);
      check_bit("model_dcache_ready", dcache_req_ready, !m_have_req[1]);
      check_bit("model_mem_v", mem_req_v, e_v);
      if (e_v) begin
        e_req = {e_src[0], m_meta[e_src], m_req[e_src]};
        check_word("model_mem_req", 64'(mem_req), 64'(e_req));
      end
      check_bit("model_icache_complete", icache_complete, dn0);
      check_bit("model_dcache_complete", dcache_complete, dn1);
      check_bit("model_credits_full", credits_full, outstanding == 2);
      check_bit("model_credits_empty", credits_empty, outstanding == 0);

      hs     = e_v && mem_req_ready;
      cap_r0 = !m_have_req[0] && icache_req_v;
      cap_r1 = !m_have_req[1] && dcache_req_v;
      cap_m0 = icache_meta_v && (cap_r0 || (m_have_req[0] && !m_have_meta[0]));
      cap_m1 = dcache_meta_v && (cap_r1 || (m_have_req[1] && !m_have_meta[1]));
      if (hs) begin
        m_issued[e_src] = 1;
        m_favor = 1 - e_src;
        m_hold = -1;
      end else if (e_v) begin
        m_hold = e_src;
      end
      if (dn0) begin m_have_req[0] = 0; m_have_meta[0] = 0; m_issued[0] = 0; end
      if (dn1) begin m_have_req[1] = 0; m_have_meta[1] = 0; m_issued[1] = 0; end
      if (cap_r0) begin m_have_req[0] = 1; m_req[0] = {8'h00, icache_req}; end
      if (cap_r1) begin m_have_req[1] = 1; m_req[1] = dcache_req; end
      if (cap_m0) begin m_have_meta[0] = 1; m_meta[0] = {2'b00, icache_meta}; end
      if (cap_m1) begin m_have_meta[1] = 1; m_meta[1] = dcache_meta; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    icache_req_v = 0; icache_meta_v = 0;
    dcache_req_v = 0; dcache_meta_v = 0;
    mem_req_ready = 0; mem_done = 0;
  endtask

  localparam logic [MW-1:0] HOLD_REQ = {1'b0, 2'b00, 4'h9, 8'h00, 40'hAB_CDEF_0123};

  initial begin
    repeat (2) tick();
    settle();
    check_bit("reset_icache_ready", icache_req_ready, 1'b0);
    check_bit("reset_empty", credits_empty, 1'b1);
    reset_i = 0;
    settle();
    check_bit("post_reset_icache_ready", icache_req_ready, 1'b1);
    check_bit("post_reset_dcache_ready", dcache_req_ready, 1'b1);
    tick();

    // I$ request then metadata, accepted on first offer
    icache_req = 40'h12_3456_789A; icache_req_v = 1;
    tick();
    icache_req_v = 0; icache_meta = 4'h5; icache_meta_v = 1;
    settle();
    check_bit("t1_no_valid", mem_req_v, 1'b0);
    tick();
    icache_meta_v = 0; mem_req_ready = 1;
    settle();
    check_bit("t2_valid", mem_req_v, 1'b1);
    check_word("t2_req", 64'(mem_req), 64'({1'b0, 2'b00, 4'h5, 8'h00, 40'h12_3456_789A}));
    tick();
    mem_req_ready = 0;
    dcache_req = 48'hBEEF_0000_CAFE; dcache_req_v = 1;
    dcache_meta = 6'h2A; dcache_meta_v = 1;
    settle();
    check_bit("t3_icache_ready", icache_req_ready, 1'b0);
    check_bit("t3_count1_empty", credits_empty, 1'b0);
    check_bit("t3_count1_full", credits_full, 1'b0);
    tick();

    // D$ same-cycle req+meta, then issue it
    clear_inputs(); mem_req_ready = 1;
    settle();
    check_word("d_req", 64'(mem_req), 64'({1'b1, 6'h2A, 48'hBEEF_0000_CAFE}));
    tick();
    clear_inputs(); mem_done = 1; mem_done_src = 0;
    settle();
    check_bit("both_out_full", credits_full, 1'b1);
    check_bit("icache_done_pulse", icache_complete, 1'b1);
    tick();

    // D$ done coincides with an I$ handshake
    clear_inputs();
    icache_req = 40'h00_0000_0C0C; icache_req_v = 1; icache_meta = 4'h3; icache_meta_v = 1;
    tick();
    clear_inputs(); mem_req_ready = 1; mem_done = 1; mem_done_src = 1;
    settle();
    check_bit("dcache_done_pulse", dcache_complete, 1'b1);
    check_bit("no_icache_pulse", icache_complete, 1'b0);
    tick();
    clear_inputs(); mem_done = 1; mem_done_src = 0;
    settle();
    check_bit("dcache_pulse_once", dcache_complete, 1'b0);
    check_bit("count_stays1_full", credits_full, 1'b0);
    check_bit("count_stays1_empty", credits_empty, 1'b0);
    tick();

    // Done aimed at an empty slot, and stray metadata, are ignored
    clear_inputs(); mem_done = 1; mem_done_src = 0; icache_meta_v = 1;
    settle();
    check_bit("stray_done_no_pulse", icache_complete, 1'b0);
    check_bit("stray_done_empty", credits_empty, 1'b1);
    tick();
    clear_inputs();
    settle();
    check_bit("stray_meta_ready", icache_req_ready, 1'b1);
    check_bit("stray_meta_no_valid", mem_req_v, 1'b0);
    tick();

    // Both become READY together after a fresh reset
    reset_i = 1;
    tick();
    reset_i = 0;
    icache_req = 40'h11_1111_1111; icache_req_v = 1; icache_meta = 4'h1; icache_meta_v = 1;
    dcache_req = 48'h2222_2222_2222; dcache_req_v = 1; dcache_meta = 6'h02; dcache_meta_v = 1;
    tick();
    clear_inputs(); mem_req_ready = 1;
    settle();
`ifdef BP_REQ_ARB_DCACHE_PRIORITY_EN
    check_bit("both_first_src", mem_req[MW-1], 1'b1);
`else
    check_bit("both_first_src", mem_req[MW-1], 1'b0);
`endif
    tick();
    settle();
`ifdef BP_REQ_ARB_DCACHE_PRIORITY_EN
    check_bit("both_second_src", mem_req[MW-1], 1'b0);
`else
    check_bit("both_second_src", mem_req[MW-1], 1'b1);
`endif
    tick();
    clear_inputs();
    settle();
    check_bit("both_full", credits_full, 1'b1);
    tick();

    // Reset while both are out at memory
    reset_i = 1; mem_done = 1; mem_done_src = 0;
    settle();
    check_bit("rst_mid_no_pulse", icache_complete, 1'b0);
    tick();
    reset_i = 0; clear_inputs();
    settle();
    check_bit("rst_mid_empty", credits_empty, 1'b1);
    check_bit("rst_mid_full", credits_full, 1'b0);
    check_bit("rst_mid_icache_ready", icache_req_ready, 1'b1);
    check_bit("rst_mid_dcache_ready", dcache_req_ready, 1'b1);
    tick();

    // Stalled offer stays locked while D$ becomes READY
    icache_req = 40'hAB_CDEF_0123; icache_req_v = 1; icache_meta = 4'h9; icache_meta_v = 1;
    tick();
    clear_inputs();
    dcache_req = 48'h3333_4444_5555; dcache_req_v = 1; dcache_meta = 6'h15; dcache_meta_v = 1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check_bit("hold_valid", mem_req_v, 1'b1);
      check_word("hold_req", 64'(mem_req), 64'(HOLD_REQ));
      tick();
      dcache_req_v = 0; dcache_meta_v = 0;
    end
    mem_req_ready = 1;
    settle();
    check_word("hold_release", 64'(mem_req), 64'(HOLD_REQ));
    tick();
    settle();
    check_word("after_hold_d", 64'(mem_req), 64'({1'b1, 6'h15, 48'h3333_4444_5555}));
    tick();

    // Done and new request to the same source in one cycle
    clear_inputs(); mem_done = 1; mem_done_src = 0;
    icache_req = 40'h77_7777_7777; icache_req_v = 1; icache_meta = 4'h7; icache_meta_v = 1;
    settle();
    check_bit("same_cycle_ready", icache_req_ready, 1'b0);
    check_bit("same_cycle_pulse", icache_complete, 1'b1);
    tick();
    clear_inputs();
    settle();
    check_bit("same_cycle_slot_empty", icache_req_ready, 1'b1);
    check_bit("same_cycle_not_taken", mem_req_v, 1'b0);
    mem_done = 1; mem_done_src = 1;
    tick();
    clear_inputs();
    settle();
    check_bit("final_empty", credits_empty, 1'b1);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
